// File: rtl/clock_pkg.sv
// Shared constants and types for the digital clock front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_pkg;

  // Button index positions inside the per-button vectors
  localparam int BTN_MODE = 0;
  localparam int BTN_SEL  = 1;
  localparam int BTN_INC  = 2;
  localparam int BTN_STOP = 3;
  localparam int NUM_BTN  = 4;

  // Auto-repeat state machine encoding for the inc button
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_WAIT   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

endpackage : clock_pkg

// File: rtl/debounce_cell.sv
// One push-button channel: 2-FF synchronizer, counting debouncer, press pulse.
// Latency: raw rise before edge k -> press high in the cycle after edge k+1+DB_CYCLES.
// Backpressure: none; the press pulse is a single-cycle strobe.
module debounce_cell
  import clock_pkg::*;
#(
  parameter int DB_CYCLES = 3,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] dcnt;

  // Two-flop synchronizer; only s2 is trusted downstream
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Flip the stable level only after DB_CYCLES consecutive disagreeing samples;
  // the press strobe is loaded on the same edge the level rises
  always_ff @(posedge clk) begin
    if (!rst) begin
      stable <= 1'b0;
      dcnt   <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (s2 == stable) begin
        dcnt <= '0;
      end else if (dcnt == DB_LAST) begin
        stable <= s2;
        dcnt   <= '0;
        press  <= s2;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

endmodule : debounce_cell

// File: rtl/button_conditioner.sv
// Conditions four raw buttons into clean press pulses, with hold-to-repeat on inc.
// Latency: press pulse DB_CYCLES+2 edges after the raw rise; first repeat REPEAT_DELAY after the press.
// Backpressure: none; outputs are single-cycle strobes consumed by the clock core.
module button_conditioner
  import clock_pkg::*;
#(
  parameter int DB_CYCLES     = 3,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_mode_raw,
  input  logic btn_sel_raw,
  input  logic btn_inc_raw,
  input  logic btn_stop_raw,
  output logic mode,
  output logic sel,
  output logic inc,
  output logic stop_alarm,
  output logic any_held
);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [NUM_BTN-1:0] raw_vec;
  logic [NUM_BTN-1:0] stable_vec;
  logic [NUM_BTN-1:0] press_vec;

  rpt_state_t         rpt_state;
  logic [CNT_W-1:0]   hcnt;
  logic               stable_inc;
  logic               rpt_fire;
  logic               mode_press;

  assign raw_vec[BTN_MODE] = btn_mode_raw;
  assign raw_vec[BTN_SEL]  = btn_sel_raw;
  assign raw_vec[BTN_INC]  = btn_inc_raw;
  assign raw_vec[BTN_STOP] = btn_stop_raw;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    debounce_cell #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw_vec[i]),
      .stable (stable_vec[i]),
      .press  (press_vec[i])
    );
  end

  assign stable_inc = stable_vec[BTN_INC];
  assign mode_press = press_vec[BTN_MODE];

  // Hold-to-repeat sequencer: wait REPEAT_DELAY after the press, then every
  // REPEAT_PERIOD; any release drops straight back to idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      rpt_state <= RPT_IDLE;
      hcnt      <= '0;
    end else begin
      case (rpt_state)
        RPT_IDLE: begin
          if (press_vec[BTN_INC]) begin
            rpt_state <= RPT_WAIT;
            hcnt      <= '0;
          end
        end
        RPT_WAIT: begin
          if (!stable_inc) begin
            rpt_state <= RPT_IDLE;
            hcnt      <= '0;
          end else if (hcnt == DELAY_LAST) begin
            rpt_state <= RPT_REPEAT;
            hcnt      <= '0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (!stable_inc) begin
            rpt_state <= RPT_IDLE;
            hcnt      <= '0;
          end else if (hcnt == PERIOD_LAST) begin
            hcnt <= '0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: begin
          rpt_state <= RPT_IDLE;
          hcnt      <= '0;
        end
      endcase
    end
  end

  // A repeat strobe is due in the cycle the hold counter sits on its terminal
  // value while the button is still down
  always_comb begin
    rpt_fire = 1'b0;
    if (stable_inc) begin
      case (rpt_state)
        RPT_WAIT:   rpt_fire = (hcnt == DELAY_LAST);
        RPT_REPEAT: rpt_fire = (hcnt == PERIOD_LAST);
        default:    rpt_fire = 1'b0;
      endcase
    end
  end

  // Level summary for the clock core, one cycle behind the debounced levels
  always_ff @(posedge clk) begin
    if (!rst) begin
      any_held <= 1'b0;
    end else begin
      any_held <= |stable_vec;
    end
  end

  // Outputs are decoded from registered strobes and state only. A mode press
  // masks sel/inc for that cycle so a mode change never adjusts a field; the
  // masked repeat is simply lost and the repeat cadence carries on unchanged.
  assign mode       = mode_press;
  assign stop_alarm = press_vec[BTN_STOP];
  assign sel        = press_vec[BTN_SEL] & ~mode_press;
  assign inc        = (press_vec[BTN_INC] | rpt_fire) & ~mode_press;

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Randomized and directed checks of button_conditioner against an edge-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_button_conditioner;

  localparam int DB = 3;
  localparam int RD = 8;
  localparam int RP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] raw = 4'b0;   // [0]=mode [1]=sel [2]=inc [3]=stop
  logic       mode, sel, inc, stop_alarm, any_held;

  button_conditioner #(
    .DB_CYCLES     (DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_mode_raw (raw[0]),
    .btn_sel_raw  (raw[1]),
    .btn_inc_raw  (raw[2]),
    .btn_stop_raw (raw[3]),
    .mode         (mode),
    .sel          (sel),
    .inc          (inc),
    .stop_alarm   (stop_alarm),
    .any_held     (any_held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit started = 1'b0;

  // ---------------- behavioural model (edge-indexed) ----------------
  bit          m_s1 [4];
  bit          m_s2 [4];
  bit          m_st [4];
  logic [15:0] m_hist [4];   // bit0 = newest synchronized sample
  bit          e_mode, e_sel, e_inc, e_stop, e_any;
  int          p_edge = 0;
  bit          alive = 1'b0;

  // True when the newest DB synchronized samples all disagree with the level
  function automatic bit all_differ(logic [15:0] h, bit s);
    logic [15:0] mask;
    mask = (16'd1 << DB) - 16'd1;
    return ((h ^ {16{s}}) & mask) == mask;
  endfunction

  always @(posedge clk) begin
    bit rose [4];
    int d;
    bit fire;
    cyc++;
    if (!rst) begin
      for (int b = 0; b < 4; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_st[b] = 0; m_hist[b] = '0;
      end
      e_mode = 0; e_sel = 0; e_inc = 0; e_stop = 0; e_any = 0;
      alive = 0;
      started = 1'b1;
    end else begin
      e_any = m_st[0] | m_st[1] | m_st[2] | m_st[3];
      for (int b = 0; b < 4; b++) begin
        m_hist[b] = {m_hist[b][14:0], m_s2[b]};
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
        rose[b] = 0;
        if (all_differ(m_hist[b], m_st[b])) begin
          m_st[b] = !m_st[b];
          rose[b] = m_st[b];
        end
      end
      // Repeat rule: level continuously high since the press edge p; pulses at
      // p+RD, then every RP edges after that
      if (rose[2]) begin
        p_edge = cyc;
        alive  = 1;
      end else if (!m_st[2]) begin
        alive = 0;
      end
      d    = cyc - p_edge;
      fire = alive && !rose[2] && (d == RD || (d > RD && ((d - RD) % RP) == 0));
      e_mode = rose[0];
      e_stop = rose[3];
      e_sel  = rose[1] && !rose[0];
      e_inc  = (rose[2] || fire) && !rose[0];
    end
  end

  // ---------------- per-cycle compare and pulse recorder ----------------
  int mode_q[$], sel_q[$], inc_q[$], stop_q[$];
  int first_any, last_any;
  bit any_seen;

  always @(negedge clk) begin
    if (started) begin
      n_tests++;
      if ({mode, sel, inc, stop_alarm, any_held} !== {e_mode, e_sel, e_inc, e_stop, e_any}) begin
        n_fail++;
        $display("FAIL cycle_compare edge=%0d actual{mode,sel,inc,stop,any}=%b required=%b",
                 cyc, {mode, sel, inc, stop_alarm, any_held}, {e_mode, e_sel, e_inc, e_stop, e_any});
      end
      if (mode === 1'b1)       mode_q.push_back(cyc);
      if (sel === 1'b1)        sel_q.push_back(cyc);
      if (inc === 1'b1)        inc_q.push_back(cyc);
      if (stop_alarm === 1'b1) stop_q.push_back(cyc);
      if (any_held === 1'b1) begin
        if (!any_seen) first_any = cyc;
        any_seen = 1'b1;
        last_any = cyc;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rec();
    mode_q.delete(); sel_q.delete(); inc_q.delete(); stop_q.delete();
    any_seen = 1'b0; first_any = -1; last_any = -1;
  endtask

  task automatic check_int(string name, int act, int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_edges(string name, int act[$], int base, int rel[$]);
    check_int({name, "_count"}, act.size(), rel.size());
    for (int i = 0; i < rel.size() && i < act.size(); i++)
      check_int(name, act[i] - base, rel[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int rel[$];
    int none[$];

    rst = 1'b0; raw = 4'b0;
    step(1);
    rst = 1'b1;
    check_int("reset_outputs", int'({mode, sel, inc, stop_alarm, any_held}), 0);
    step(10);

    // Clean sel press: rise before base+1, held 20 cycles
    clear_rec(); base = cyc;
    raw[1] = 1'b1; step(20);
    raw[1] = 1'b0; step(12);
    rel = '{5};
    check_edges("clean_sel", sel_q, base, rel);
    check_int("clean_any_first", first_any - base, 6);
    check_int("clean_any_last", last_any - base, 25);
    check_int("clean_no_other", mode_q.size() + inc_q.size() + stop_q.size(), 0);

    // Bouncy mode: 1,0,1,0 then settled high from before base+5
    clear_rec(); base = cyc;
    raw[0] = 1'b1; step(1);
    raw[0] = 1'b0; step(1);
    raw[0] = 1'b1; step(1);
    raw[0] = 1'b0; step(1);
    raw[0] = 1'b1; step(15);
    raw[0] = 1'b0; step(12);
    rel = '{9};
    check_edges("bounce_mode", mode_q, base, rel);

    // Two-cycle glitch is discarded
    clear_rec(); base = cyc;
    raw[0] = 1'b1; step(2);
    raw[0] = 1'b0; step(12);
    check_edges("glitch_mode", mode_q, base, none);

    // Auto-repeat: inc held 40 cycles
    clear_rec(); base = cyc;
    raw[2] = 1'b1; step(40);
    raw[2] = 1'b0; step(15);
    rel = '{5, 13, 17, 21, 25, 29, 33, 37, 41};
    check_edges("repeat_inc", inc_q, base, rel);

    // Mode and inc together: inc press masked, repeats keep their cadence
    clear_rec(); base = cyc;
    raw[0] = 1'b1; raw[2] = 1'b1; step(20);
    raw = 4'b0; step(12);
    rel = '{5};
    check_edges("prio_mode", mode_q, base, rel);
    rel = '{13, 17, 21};
    check_edges("prio_inc", inc_q, base, rel);

    // Stop and mode together: both pass
    clear_rec(); base = cyc;
    raw[0] = 1'b1; raw[3] = 1'b1; step(6);
    raw = 4'b0; step(12);
    rel = '{5};
    check_edges("prio_stop_mode", mode_q, base, rel);
    check_edges("prio_stop", stop_q, base, rel);

    // Sel and inc together: both pass
    clear_rec(); base = cyc;
    raw[1] = 1'b1; raw[2] = 1'b1; step(6);
    raw = 4'b0; step(12);
    rel = '{5};
    check_edges("both_sel", sel_q, base, rel);
    check_edges("both_inc", inc_q, base, rel);

    // Reset in the middle of an inc hold
    clear_rec(); base = cyc;
    raw[2] = 1'b1; step(14);
    rst = 1'b0; step(1);
    check_int("midhold_reset_outputs", int'({mode, sel, inc, stop_alarm, any_held}), 0);
    rst = 1'b1; step(15);
    raw[2] = 1'b0; step(12);
    rel = '{5, 13, 20, 28, 32};
    check_edges("midhold_inc", inc_q, base, rel);

    // Randomized bouncy activity with occasional resets, checked every cycle
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 11) == 0) raw[b] = ~raw[b];
      end
      rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    rst = 1'b1; raw = 4'b0;
    step(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_button_conditioner
